// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared definitions for the VGA raster sequencer: 640x480@60 default
//   geometry, frame/line total helpers, and the phase decode used by both
//   the horizontal and the vertical axis.
package vga_timing_pkg;

    // Default 640x480@60 geometry (pixel clock ~25.175 MHz)
    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FP_DEF      = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BP_DEF      = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FP_DEF      = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BP_DEF      = 33;
    localparam int unsigned PIPE_DLY_DEF  = 2;
    localparam int unsigned PIPE_DLY_MAX  = 4;

    // Raster counters are 10 bits wide; totals must fit.
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned MAX_TOTAL = 1024;

    typedef enum logic [1:0] {
        PH_ACT,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_e;

    function automatic int unsigned h_total(input int unsigned vis, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned vis, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

    // Phase of one axis given its count; anything past the sync region is back porch.
    function automatic phase_e phase_of(input logic [CNT_W-1:0] cnt, input int unsigned vis,
                                        input int unsigned fp, input int unsigned sync);
        int unsigned c;
        c = 32'(cnt);
        if (c < vis)
            return PH_ACT;
        else if (c < vis + fp)
            return PH_FP;
        else if (c < vis + fp + sync)
            return PH_SYNC;
        return PH_BP;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay
//   WIDTH-bit shift register of DEPTH stages with an asynchronous reset that
//   loads every stage with rst_val_i. DEPTH=0 is a wire.
//   Ports:
//     clk_i      clock
//     rst_n_i    asynchronous active-low reset
//     rst_val_i  value loaded into every stage on reset
//     d_i        data in
//     q_o        data out, DEPTH clocks after d_i
module vga_sync_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] rst_val_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_pass;
        assign unused_pass = ^{clk_i, rst_n_i, rst_val_i};
        assign q_o = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] sr_q [DEPTH];

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                for (int unsigned i = 0; i < DEPTH; i++)
                    sr_q[i] <= rst_val_i;
            end else begin
                sr_q[0] <= d_i;
                for (int unsigned i = 1; i < DEPTH; i++)
                    sr_q[i] <= sr_q[i-1];
            end
        end

        assign q_o = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   Raster sequencer for the VGA output path. Produces pixel coordinates for
//   the pixel generators and the sync/blank/RGB outputs, the latter delayed by
//   PIPE_DLY+1 clocks so they line up with the generators' pixels.
//   Ports:
//     iVGA_CLK              pixel clock
//     iRST_n                asynchronous active-low reset
//     iEN                   advance raster when high, hold when low
//     iRed/iGreen/iBlue     generator pixel, PIPE_DLY clocks after its X/Y
//     oVGA_X/oVGA_Y         raw horizontal/vertical counts (including blanking)
//     oActive               X/Y inside the visible window
//     oLineStart            pulse while X==0 is presented (and iEN high)
//     oFrameStart           pulse while (0,0) is presented (and iEN high)
//     oHS/oVS               syncs, asserted level SYNC_ACT, aligned with RGB
//     oBLANK_n              high in the visible region, aligned with RGB
//     oRed/oGreen/oBlue     pixel output, zero outside the visible region
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF,
    parameter int unsigned PIPE_DLY  = PIPE_DLY_DEF,
    parameter bit          SYNC_ACT  = 1'b0
) (
    input  logic             iVGA_CLK,
    input  logic             iRST_n,
    input  logic             iEN,
    input  logic [3:0]       iRed,
    input  logic [3:0]       iGreen,
    input  logic [3:0]       iBlue,
    output logic [CNT_W-1:0] oVGA_X,
    output logic [CNT_W-1:0] oVGA_Y,
    output logic             oActive,
    output logic             oLineStart,
    output logic             oFrameStart,
    output logic             oHS,
    output logic             oVS,
    output logic             oBLANK_n,
    output logic [3:0]       oRed,
    output logic [3:0]       oGreen,
    output logic [3:0]       oBlue
);

    localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
        $error("vga_timing_ctrl: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
        $error("vga_timing_ctrl: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
    end
    if (PIPE_DLY > PIPE_DLY_MAX) begin : g_pipe_chk
        $error("vga_timing_ctrl: PIPE_DLY %0d exceeds %0d", PIPE_DLY, PIPE_DLY_MAX);
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Delay-line word {hs, vs, active}; reset/idle state is deasserted and blank.
    localparam logic [2:0] SYNC_IDLE = {~SYNC_ACT, ~SYNC_ACT, 1'b0};

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (iEN) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    phase_e hphase, vphase;
    logic   hs_raw, vs_raw, active_raw;

    assign hphase     = phase_of(hcount_q, H_VISIBLE, H_FP, H_SYNC);
    assign vphase     = phase_of(vcount_q, V_VISIBLE, V_FP, V_SYNC);
    assign hs_raw     = (hphase == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    assign vs_raw     = (vphase == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    assign active_raw = (hphase == PH_ACT) && (vphase == PH_ACT);

    assign oVGA_X  = hcount_q;
    assign oVGA_Y  = vcount_q;
    assign oActive = active_raw;

    // Pulses are decoded from the held counts, so they must be qualified by
    // iEN (a held position is not a new line) and by reset (counts read 0
    // while in reset but no line is being started).
    assign oLineStart  = iRST_n && iEN && (hcount_q == '0);
    assign oFrameStart = iRST_n && iEN && (hcount_q == '0) && (vcount_q == '0);

    logic [2:0] dly_out;

    vga_sync_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_DLY)
    ) u_sync_delay (
        .clk_i     (iVGA_CLK),
        .rst_n_i   (iRST_n),
        .rst_val_i (SYNC_IDLE),
        .d_i       ({hs_raw, vs_raw, active_raw}),
        .q_o       (dly_out)
    );

    logic       hs_q, vs_q, blank_n_q;
    logic [3:0] red_q, green_q, blue_q;

    // The delayed active flag is the blank gate for the pixel arriving now.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hs_q      <= ~SYNC_ACT;
            vs_q      <= ~SYNC_ACT;
            blank_n_q <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            hs_q      <= dly_out[2];
            vs_q      <= dly_out[1];
            blank_n_q <= dly_out[0];
            red_q     <= dly_out[0] ? iRed   : '0;
            green_q   <= dly_out[0] ? iGreen : '0;
            blue_q    <= dly_out[0] ? iBlue  : '0;
        end
    end

    assign oHS      = hs_q;
    assign oVS      = vs_q;
    assign oBLANK_n = blank_n_q;
    assign oRed     = red_q;
    assign oGreen   = green_q;
    assign oBlue    = blue_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
module tb_vga_timing_ctrl;

    // Reduced geometry keeps full frames short; one default instance covers 640x480.
    localparam int unsigned HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int unsigned VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HV + HF + HS + HB;   // 30
    localparam int unsigned VT = VV + VF + VS + VB;   // 19
    localparam int unsigned FT = HT * VT;             // 570

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [3:0] red = 4'h0, grn = 4'h0, blu = 4'h0;

    always #5 clk = ~clk;

    // index k -> PIPE_DLY = 2*k
    logic [9:0] x [3];
    logic [9:0] y [3];
    logic       act [3];
    logic       ls [3];
    logic       fs [3];
    logic       hs [3];
    logic       vs [3];
    logic       bl [3];
    logic [3:0] r [3];
    logic [3:0] g [3];
    logic [3:0] b [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        vga_timing_ctrl #(
            .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
            .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
            .PIPE_DLY  (2 * k), .SYNC_ACT (1'b0)
        ) u_dut (
            .iVGA_CLK (clk), .iRST_n (rst_n), .iEN (en),
            .iRed (red), .iGreen (grn), .iBlue (blu),
            .oVGA_X (x[k]), .oVGA_Y (y[k]), .oActive (act[k]),
            .oLineStart (ls[k]), .oFrameStart (fs[k]),
            .oHS (hs[k]), .oVS (vs[k]), .oBLANK_n (bl[k]),
            .oRed (r[k]), .oGreen (g[k]), .oBlue (b[k])
        );
    end

    logic [9:0] dx, dy;
    logic       dact, dls, dfs, dhs, dvs, dbl;
    logic [3:0] dr, dg, db;

    vga_timing_ctrl u_dut_def (
        .iVGA_CLK (clk), .iRST_n (rst_n), .iEN (en),
        .iRed (red), .iGreen (grn), .iBlue (blu),
        .oVGA_X (dx), .oVGA_Y (dy), .oActive (dact),
        .oLineStart (dls), .oFrameStart (dfs),
        .oHS (dhs), .oVS (dvs), .oBLANK_n (dbl),
        .oRed (dr), .oGreen (dg), .oBlue (db)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } raw_t;

    raw_t        sbq[$];
    int unsigned mx, my;
    logic [3:0]  pr, pg, pb;
    bit          mon_on = 1'b0;

    // Restart the model at (0,0); the delay line holds idle words after reset.
    task automatic sb_reset();
        sbq.delete();
        repeat (5) sbq.push_back(raw_t'(3'b110));
        mx = 0;
        my = 0;
        pr = '0;
        pg = '0;
        pb = '0;
    endtask

    always @(negedge clk) begin : mon
        raw_t cur, e;
        logic exp_ls, exp_fs;
        if (mon_on) begin
            cur.hs  = !((mx >= HV + HF) && (mx < HV + HF + HS));
            cur.vs  = !((my >= VV + VF) && (my < VV + VF + VS));
            cur.act = (mx < HV) && (my < VV);
            exp_ls  = en && (mx == 0);
            exp_fs  = en && (mx == 0) && (my == 0);

            n_checks++;
            if (x[1] !== 10'(mx) || y[1] !== 10'(my))
                $display("FAIL xy_pos: got (%0d,%0d) expected (%0d,%0d)", x[1], y[1], mx, my);
            else n_pass++;
            n_checks++;
            if (act[1] !== cur.act)
                $display("FAIL active: got %b expected %b at (%0d,%0d)", act[1], cur.act, mx, my);
            else n_pass++;
            n_checks++;
            if ({ls[1], fs[1]} !== {exp_ls, exp_fs})
                $display("FAIL pulses: got ls=%b fs=%b expected ls=%b fs=%b at (%0d,%0d)",
                         ls[1], fs[1], exp_ls, exp_fs, mx, my);
            else n_pass++;

            sbq.push_back(cur);
            for (int k = 0; k < 3; k++) begin
                e = sbq[sbq.size() - 2 - 2 * k];
                n_checks++;
                if ({hs[k], vs[k], bl[k]} !== {e.hs, e.vs, e.act})
                    $display("FAIL sync_blank[pipe=%0d]: got hs/vs/blank=%b%b%b expected %b%b%b",
                             2 * k, hs[k], vs[k], bl[k], e.hs, e.vs, e.act);
                else n_pass++;
                n_checks++;
                if ({r[k], g[k], b[k]} !== (e.act ? {pr, pg, pb} : 12'h000))
                    $display("FAIL rgb[pipe=%0d]: got %h expected %h", 2 * k,
                             {r[k], g[k], b[k]}, (e.act ? {pr, pg, pb} : 12'h000));
                else n_pass++;
            end
            sbq.delete(0);

            pr = red;
            pg = grn;
            pb = blu;
            if (en) begin
                if (mx == HT - 1) begin
                    mx = 0;
                    my = (my == VT - 1) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic run_to(input int unsigned tx, input int unsigned ty);
        bit hit;
        hit = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 2 * FT && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = (x[1] == 10'(tx)) && (y[1] == 10'(ty));
        end
        n_checks++;
        if (!hit) $display("FAIL run_to: position (%0d,%0d) not reached, at (%0d,%0d)", tx, ty, x[1], y[1]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        red   = 4'hF;
        grn   = 4'hA;
        blu   = 4'h5;
        #12;
        n_checks++;
        if ({x[1], y[1]} !== 20'h0) $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", x[1], y[1]);
        else n_pass++;
        n_checks++;
        if ({act[1], ls[1], fs[1]} !== 3'b100)
            $display("FAIL reset_act_pulses: got %b%b%b expected 100", act[1], ls[1], fs[1]);
        else n_pass++;
        n_checks++;
        if ({hs[1], vs[1], bl[1]} !== 3'b110)
            $display("FAIL reset_sync: got hs/vs/blank=%b%b%b expected 110", hs[1], vs[1], bl[1]);
        else n_pass++;
        n_checks++;
        if ({r[1], g[1], b[1]} !== 12'h000) $display("FAIL reset_rgb: got %h expected 000", {r[1], g[1], b[1]});
        else n_pass++;
        n_checks++;
        if ({dx, dhs, dvs, dbl} !== {10'd0, 3'b110})
            $display("FAIL reset_default: got x=%0d hs/vs/blank=%b%b%b expected x=0 110", dx, dhs, dvs, dbl);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_reset();
        mon_on = 1'b1;
    endtask

    task automatic test_free_run();
        int nls = 0, nfs = 0, nred = 0, nbl = 0, nhs = 0, nvs = 0;
        int ff [3];
        int fdef = -1;
        for (int k = 0; k < 3; k++) ff[k] = -1;
        for (int c = 0; c < 2 * FT + 3; c++) begin
            @(negedge clk);
            if (c < 2 * FT) begin
                nls += int'(ls[1]);
                nfs += int'(fs[1]);
            end
            nred += int'(r[1] != 4'h0);
            nbl  += int'(bl[1]);
            nhs  += int'(!hs[1]);
            nvs  += int'(!vs[1]);
            for (int k = 0; k < 3; k++)
                if (hs[k] == 1'b0 && ff[k] < 0) ff[k] = c;
            if (dhs == 1'b0 && fdef < 0) fdef = c;
            if (c == 799) begin
                n_checks++;
                if (dx !== 10'd799) $display("FAIL default_x799: got %0d expected 799", dx);
                else n_pass++;
            end
            if (c == 800) begin
                n_checks++;
                if ({dx, dy} !== {10'd0, 10'd1}) $display("FAIL default_wrap: got (%0d,%0d) expected (0,1)", dx, dy);
                else n_pass++;
            end
        end
        n_checks++;
        if (nls != 2 * VT) $display("FAIL line_pulses: got %0d expected %0d", nls, 2 * VT);
        else n_pass++;
        n_checks++;
        if (nfs != 2) $display("FAIL frame_pulses: got %0d expected 2", nfs);
        else n_pass++;
        n_checks++;
        if (nred != 2 * HV * VV) $display("FAIL red_nonzero: got %0d expected %0d", nred, 2 * HV * VV);
        else n_pass++;
        n_checks++;
        if (nbl != 2 * HV * VV) $display("FAIL blank_count: got %0d expected %0d", nbl, 2 * HV * VV);
        else n_pass++;
        n_checks++;
        if (nhs != 2 * VT * HS) $display("FAIL hs_low_count: got %0d expected %0d", nhs, 2 * VT * HS);
        else n_pass++;
        n_checks++;
        if (nvs != 2 * VS * HT) $display("FAIL vs_low_count: got %0d expected %0d", nvs, 2 * VS * HT);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ff[k] != int'(HV + HF) + 2 * k + 1)
                $display("FAIL hs_fall[pipe=%0d]: got cycle %0d expected %0d", 2 * k, ff[k], HV + HF + 2 * k + 1);
            else n_pass++;
        end
        n_checks++;
        if (fdef != 659) $display("FAIL hs_fall_default: got cycle %0d expected 659", fdef);
        else n_pass++;
    endtask

    task automatic test_hold();
        run_to(HV - 1, 5);
        en = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        n_checks++;
        if ({x[1], y[1]} !== {10'(HV - 1), 10'd5})
            $display("FAIL hold_xy: got (%0d,%0d) expected (%0d,5)", x[1], y[1], HV - 1);
        else n_pass++;
        n_checks++;
        if ({ls[1], fs[1], bl[1]} !== 3'b001)
            $display("FAIL hold_state: got ls/fs/blank=%b%b%b expected 001", ls[1], fs[1], bl[1]);
        else n_pass++;
        en = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({x[1], y[1]} !== {10'(HV), 10'd5}) $display("FAIL resume_xy: got (%0d,%0d) expected (%0d,5)", x[1], y[1], HV);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bl[1] !== 1'b1) $display("FAIL resume_blank_hi: got %b expected 1", bl[1]);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (bl[1] !== 1'b0) $display("FAIL resume_blank_fall: got %b expected 0", bl[1]);
        else n_pass++;
    endtask

    task automatic test_random_en(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
            en  = ($urandom_range(0, 3) != 0);
            red = 4'($urandom);
            grn = 4'($urandom);
            blu = 4'($urandom);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
    endtask

    task automatic test_frame_wrap();
        run_to(HT - 1, VT - 1);
        @(posedge clk);
        #1;
        n_checks++;
        if ({x[1], y[1], ls[1], fs[1]} !== {20'h0, 2'b11})
            $display("FAIL wrap_first: got (%0d,%0d) ls=%b fs=%b expected (0,0) 1 1", x[1], y[1], ls[1], fs[1]);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({x[1], y[1], ls[1], fs[1]} !== {10'd1, 10'd0, 2'b00})
            $display("FAIL wrap_second: got (%0d,%0d) ls=%b fs=%b expected (1,0) 0 0", x[1], y[1], ls[1], fs[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        red = 4'hF;
        grn = 4'h3;
        blu = 4'hC;
        run_to(10, 7);
        mon_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({hs[k], vs[k], bl[k], r[k], g[k], b[k]} !== {3'b110, 12'h000})
                $display("FAIL midreset_out[pipe=%0d]: got hs/vs/blank=%b%b%b rgb=%h expected 110 000",
                         2 * k, hs[k], vs[k], bl[k], {r[k], g[k], b[k]});
            else n_pass++;
        end
        n_checks++;
        if ({x[1], y[1], ls[1], fs[1]} !== 22'h0)
            $display("FAIL midreset_xy: got (%0d,%0d) ls=%b fs=%b expected (0,0) 0 0", x[1], y[1], ls[1], fs[1]);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_reset();
        mon_on = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({x[1], y[1]} !== {10'd1, 10'd0}) $display("FAIL post_reset_xy: got (%0d,%0d) expected (1,0)", x[1], y[1]);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_free_run();
        test_hold();
        test_random_en(400);
        test_frame_wrap();
        test_reset_mid();
        test_random_en(200);
        @(negedge clk);
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Raster sequencer for the VGA output path. Generates the pixel coordinates (oVGA_X, oVGA_Y) consumed by the pixel generators, such as the border/grid overlay. It also produces HSYNC, VSYNC and blanking, delayed to match those generators' pipeline latency, and forces RGB to zero outside the visible window. It sits between the pixel generators and the DAC/connector pins.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- PIPE_DLY, 2, pixel-generator latency in clocks, from X/Y to RGB; legal range 0..4
- SYNC_ACT, 0, asserted level of oHS/oVS (0 = active-low)

Ports:
- iVGA_CLK  in  1  pixel clock
- iRST_n  in  1  reset; asynchronous, active-low
- iEN  in  1  advance raster when high; hold when low
- iRed/iGreen/iBlue  in  4 each  pixel from generators, PIPE_DLY clocks after its X/Y
- oVGA_X  out  10  horizontal count 0..H_TOTAL-1
- oVGA_Y  out  10  vertical count 0..V_TOTAL-1
- oActive  out  1  X/Y inside visible window, aligned with X/Y
- oLineStart  out  1  one-clock pulse, aligned with X==0
- oFrameStart  out  1  one-clock pulse, aligned with X==0 && Y==0
- oHS, oVS  out  1  sync, aligned with oRed/oGreen/oBlue
- oBLANK_n  out  1  high in visible region, aligned with RGB
- oRed/oGreen/oBlue  out  4 each  gated pixel output

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Both totals must be ≤1024; violation is an elaboration error.
- Horizontal phase FSM, driven by hcount: H_ACT (0..639) -> H_FP (640..655) -> H_SYNC (656..751) -> H_BP (752..799) -> H_ACT.
- Vertical phase FSM is identical in form, driven by vcount: V_ACT, V_FP, V_SYNC (490..491), V_BP.
- Sync is asserted (level SYNC_ACT) in the SYNC phase and deasserted otherwise.
- On an enabled clock, hcount increments. At H_TOTAL-1, hcount wraps to 0 and vcount increments. At V_TOTAL-1 with hcount at H_TOTAL-1, vcount also wraps to 0.
- oVGA_X/oVGA_Y present the raw counts, including blanking values ≥640/≥480. Generators may draw there; the output gate zeroes it.
- oActive = (hcount<H_VISIBLE) && (vcount<V_VISIBLE).
- Raw sync and active signals enter a delay line of depth PIPE_DLY, then one output register.
- RGB output register: oRed <= blank_dly ? iRed : 0 (same for green and blue).
- iEN low: counters, oActive and the pulses hold; pulses are forced to 0. The delay line keeps shifting, so outputs settle to the held position's values PIPE_DLY+1 clocks later.

## Timing
- Reset (asynchronous, all registers):
  - hcount = vcount = 0
  - oActive = 1 (position (0,0))
  - oLineStart = oFrameStart = 0
  - oHS = oVS = ~SYNC_ACT
  - oBLANK_n = 0; RGB = 0
  - delay line filled with the deasserted/blank state
- The first enabled clock after reset release advances to (1,0). Position (0,0) is presented from release until that edge.
- Pulses: combinational from the counts, gated by iEN, and high only while presented.
- Latency: X/Y at cycle t maps to oHS/oVS/oBLANK_n/RGB at cycle t+PIPE_DLY+1. iRed at cycle t maps to oRed at t+1.
- Reset mid-frame: all outputs return to reset values immediately. The raster restarts at (0,0) with no partial-line recovery.
- Simultaneous H and V wrap: a single clock produces (0,0) and asserts both pulses.

## Structure
- Package vga_timing_pkg holds:
  - 640x480@60 default constants
  - H_TOTAL/V_TOTAL functions
  - phase enum {ACT, FP, SYNC, BP}
- Sub-module vga_sync_delay: parameterized WIDTH/DEPTH shift register with async reset value input. DEPTH=0 is a pass-through. It carries {hs, vs, active}.
- Phase decode logic is shared by H and V through a package function.

## Test plan
- Free-run 2 frames, PIPE_DLY=2: 800 clocks per line, 420000 per frame. oHS low for 96 clocks starting at t(X=656)+3. oVS low for exactly 2 lines starting at line 490.
- Drive iRed=4'hF constantly: oRed=F only while oBLANK_n=1, giving exactly 640×480 nonzero samples per frame. oRed=0 at X≥640 despite the input.
- Hold iEN low at (639,100) for 50 clocks: X/Y frozen, pulses 0. oBLANK_n still 1 three clocks later; resumes at (640,100) with oBLANK_n falling 3 clocks after.
- Assert iRST_n low at (400,300): oHS=oVS=1, oBLANK_n=0 and RGB=0 immediately. After release, the first enabled edge gives (1,0).
- At (799,524) with iEN=1: next cycle (0,0), oFrameStart=oLineStart=1 for one clock only.
- Sweep PIPE_DLY=0 and 4: oHS falling edge at t(X=656)+1 and +5 respectively.
